regfile_scoreboard: RTL and testbench

- Parametrised successor to the CPU's 32x32 two-read/one-write register file.
- Adds the following features:
  - configurable data width, depth and number of read ports;
  - optional hardwired-zero entry 0;
  - optional write-to-read bypass;
  - a sequenced post-reset clear of the array;
  - a per-register pending-write scoreboard that the decode stage uses for hazard detection.
- Sits between the decode stage (reads, reservations) and writeback (writes).

---
 rtl/regfile_scoreboard.sv | 176 +++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired-zero entry, write bypass, a sequenced
// post-reset clear and a per-register pending-write scoreboard for decode hazards.
module regfile_scoreboard #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREAD*AWIDTH-1:0]   ra,
    output logic [NREAD*DWIDTH-1:0]   rd,
    output logic [NREAD-1:0]          rd_busy,
    input  logic                      we,
    input  logic [AWIDTH-1:0]         wa,
    input  logic [DWIDTH-1:0]         wd,
    input  logic                      rsv_en,
    input  logic [AWIDTH-1:0]         rsv_addr,
    output logic                      init_done
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] CLR_LAST = (AWIDTH + 1)'(DEPTH - 1);
    localparam logic [AWIDTH:0] CLR_ONE  = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH:0]     clr_cnt_q, clr_cnt_d;
    logic                init_done_q, init_done_d;
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [DWIDTH-1:0]   mem_q [DEPTH];

    logic                wr_en_s;
    logic [AWIDTH-1:0]   wr_addr_s;
    logic [DWIDTH-1:0]   wr_data_s;
    logic                zero_wa_s;
    logic                zero_rsv_s;

    assign zero_wa_s  = (ZERO_REG != 0) && (wa == {AWIDTH{1'b0}});
    assign zero_rsv_s = (ZERO_REG != 0) && (rsv_addr == {AWIDTH{1'b0}});

    // Clear-sweep sequencing: walk clr_cnt across the array, then settle in READY.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + CLR_ONE;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end else begin
                    state_d     = ST_CLEAR;
                    init_done_d = 1'b0;
                end
            end
            ST_READY: begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = ST_CLEAR;
                clr_cnt_d   = {(AWIDTH + 1){1'b0}};
                init_done_d = 1'b0;
            end
        endcase
    end

    // Control state and registered init_done, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= {(AWIDTH + 1){1'b0}};
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // Single array write port: the clear sweep owns it until READY; reset edges never write.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = clr_cnt_q[AWIDTH-1:0];
        wr_data_s = {DWIDTH{1'b0}};
        if (!rst_n) begin
            wr_en_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_cnt_q[AWIDTH-1:0];
            wr_data_s = {DWIDTH{1'b0}};
        end else if (we && !zero_wa_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = wa;
            wr_data_s = wd;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Storage array; contents survive reset and are zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Scoreboard update: the clear from writeback is applied first so a same-address
    // reservation from the newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (state_q == ST_READY) begin
            if (we) begin
                busy_d[wa] = 1'b0;
            end else begin
                busy_d = busy_q;
            end
            if (rsv_en && !zero_rsv_s) begin
                busy_d[rsv_addr] = 1'b1;
            end else begin
                busy_d[0] = busy_d[0];
            end
        end else begin
            busy_d = busy_q;
        end
    end

    // Scoreboard register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= {DEPTH{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AWIDTH-1:0] addr_s;
        logic [DWIDTH-1:0] data_s;
        logic              busy_s;

        assign addr_s = ra[gi*AWIDTH +: AWIDTH];

        // Read mux: outputs are quiet until the array has been cleared.
        always_comb begin
            data_s = {DWIDTH{1'b0}};
            busy_s = 1'b0;
            if (state_q != ST_READY) begin
                data_s = {DWIDTH{1'b0}};
                busy_s = 1'b0;
            end else if ((ZERO_REG != 0) && (addr_s == {AWIDTH{1'b0}})) begin
                data_s = {DWIDTH{1'b0}};
                busy_s = 1'b0;
            end else if ((BYPASS != 0) && we && (wa == addr_s)) begin
                data_s = wd;
                busy_s = busy_q[addr_s];
            end else begin
                data_s = mem_q[addr_s];
                busy_s = busy_q[addr_s];
            end
        end

        assign rd[gi*DWIDTH +: DWIDTH] = data_s;
        assign rd_busy[gi]             = busy_s;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default build, a no-zero/no-bypass build
// sharing its stimulus, and a wide/shallow four-port build.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  ra = 10'd0;
    logic [63:0] rd;
    logic [1:0]  rd_busy;
    logic        we = 1'b0;
    logic [4:0]  wa = 5'd0;
    logic [31:0] wd = 32'd0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_addr = 5'd0;
    logic        init_done;

    logic [63:0] rd_b;
    logic [1:0]  busy_b;
    logic        init_b;

    logic [11:0]  ra_w = 12'd0;
    logic [255:0] rd_w;
    logic [3:0]   busy_w;
    logic         we_w = 1'b0;
    logic [2:0]   wa_w = 3'd0;
    logic [63:0]  wd_w = 64'd0;
    logic         rsv_en_w = 1'b0;
    logic [2:0]   rsv_addr_w = 3'd0;
    logic         init_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .init_done(init_done)
    );

    regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_busy(busy_b),
        .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .init_done(init_b)
    );

    regfile_scoreboard #(.DWIDTH(64), .AWIDTH(3), .NREAD(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .ra(ra_w), .rd(rd_w), .rd_busy(busy_w),
        .we(we_w), .wa(wa_w), .wd(wd_w), .rsv_en(rsv_en_w), .rsv_addr(rsv_addr_w),
        .init_done(init_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts edges from the current point until init_done rises; 41 means it never did.
    task automatic wait_init(output int edges, output int w_edges, output int quiet_bad);
        edges = 41;
        w_edges = 0;
        quiet_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (rd !== 64'd0 || rd_b !== 64'd0 || rd_busy !== 2'b00) quiet_bad++;
            if (init_done !== 1'b0) quiet_bad++;
            tick();
            if (init_w === 1'b1 && w_edges == 0) w_edges = k;
            if (init_done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    function automatic logic [63:0] wide_val(input logic [2:0] a);
        return (a == 3'd0) ? 64'd0 : 64'h1111_1111_1111_1111 * 64'(a);
    endfunction

    int n_edges;
    int n_w;
    int n_bad;
    logic [2:0] pa [4];

    initial begin
        // Reset held for three edges, with write/reserve traffic that must be ignored.
        tick(); tick(); tick();
        check("reset_init_done", {63'd0, init_done}, 64'd0);
        check("reset_init_w", {63'd0, init_w}, 64'd0);
        check("reset_busy", {62'd0, rd_busy}, 64'd0);
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd5, 5'd5};
        rsv_en = 1'b1; rsv_addr = 5'd5;
        rst_n = 1'b1;
        #1;
        wait_init(n_edges, n_w, n_bad);
        check("sweep_edges", 64'(n_edges), 64'd32);
        check("sweep_edges_wide", 64'(n_w), 64'd8);
        check("clear_quiet", 64'(n_bad), 64'd0);
        we = 1'b0; rsv_en = 1'b0;
        #1;
        check("entry5_after_clear", rd, 64'd0);
        check("entry5_after_clear_b", rd_b, 64'd0);
        check("entry5_not_busy", {62'd0, rd_busy}, 64'd0);

        // Write with both ports aliasing the target.
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra = {5'd7, 5'd7};
        #1;
        check("bypass_same_cycle", rd, 64'h12345678_12345678);
        check("nobypass_same_cycle", rd_b, 64'd0);
        tick();
        we = 1'b0;
        #1;
        check("bypass_after_edge", rd, 64'h12345678_12345678);
        check("nobypass_after_edge", rd_b, 64'h12345678_12345678);

        // Zero register: write and reserve entry 0.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 5'd0;
        ra = {5'd0, 5'd0};
        #1;
        check("zero_same_cycle", rd, 64'd0);
        tick();
        we = 1'b0; rsv_en = 1'b0;
        #1;
        check("zero_rd", rd, 64'd0);
        check("zero_busy", {62'd0, rd_busy}, 64'd0);
        check("nozero_rd", rd_b, 64'hFFFFFFFF_FFFFFFFF);
        check("nozero_busy", {62'd0, busy_b}, 64'd3);

        // Scoreboard: reserve 3, then retire it.
        ra = {5'd4, 5'd3};
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        check("rsv_not_yet", {63'd0, rd_busy[0]}, 64'd0);
        tick();
        rsv_en = 1'b0;
        #1;
        check("rsv_visible", {63'd0, rd_busy[0]}, 64'd1);
        we = 1'b1; wa = 5'd3; wd = 32'h00000033;
        #1;
        check("busy_no_bypass", {63'd0, rd_busy[0]}, 64'd1);
        tick();
        we = 1'b0;
        #1;
        check("write_clears", {63'd0, rd_busy[0]}, 64'd0);
        we = 1'b1; wa = 5'd3; rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        we = 1'b0; rsv_en = 1'b0;
        #1;
        check("same_edge_rsv_wins", {63'd0, rd_busy[0]}, 64'd1);
        we = 1'b1; wa = 5'd3; rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        we = 1'b0; rsv_en = 1'b0;
        #1;
        check("split_edge", {62'd0, rd_busy}, 64'd2);

        // Reset in READY with 3 and 9 busy.
        rsv_en = 1'b1; rsv_addr = 5'd3; tick();
        rsv_addr = 5'd9; tick();
        rsv_en = 1'b0; ra = {5'd9, 5'd3};
        #1;
        check("busy_3_9", {62'd0, rd_busy}, 64'd3);
        rst_n = 1'b0;
        tick();
        check("ready_reset_busy", {62'd0, rd_busy}, 64'd0);
        check("ready_reset_init", {63'd0, init_done}, 64'd0);

        // Release, interrupt the sweep at clr_cnt=10, then release again.
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("mid_sweep_low", {63'd0, init_done}, 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        wait_init(n_edges, n_w, n_bad);
        check("restart_edges", 64'(n_edges), 64'd32);
        check("restart_quiet", 64'(n_bad), 64'd0);
        #1;
        check("scoreboard_reset", {62'd0, rd_busy}, 64'd0);
        ra = {5'd9, 5'd7};
        #1;
        check("entry7_recleared", rd[31:0], 64'd0);

        // Wide build: fill 1..7, then two sets of four distinct read addresses.
        for (int i = 1; i <= 7; i++) begin
            we_w = 1'b1; wa_w = 3'(i); wd_w = wide_val(3'(i));
            tick();
        end
        we_w = 1'b0;
        pa[0] = 3'd7; pa[1] = 3'd2; pa[2] = 3'd5; pa[3] = 3'd1;
        ra_w = {pa[3], pa[2], pa[1], pa[0]};
        #1;
        for (int p = 0; p < 4; p++) check($sformatf("wide_a_p%0d", p), rd_w[p*64 +: 64], wide_val(pa[p]));
        pa[0] = 3'd6; pa[1] = 3'd4; pa[2] = 3'd3; pa[3] = 3'd0;
        ra_w = {pa[3], pa[2], pa[1], pa[0]};
        #1;
        for (int p = 0; p < 4; p++) check($sformatf("wide_b_p%0d", p), rd_w[p*64 +: 64], wide_val(pa[p]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
